pc_fetch_unit: RTL and testbench



---
 rtl/pc_fetch_unit.sv | 136 +++++++++++++
 tb/tb_pc_fetch_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Fetch stage: holds the PC, indexes instruction memory and registers the fetched word toward decode.
// Optional performance counters are enabled with `define FETCH_PERF_EN.
module pc_fetch_unit #(
    parameter int          IMEM_DEPTH = 32,
    parameter logic [31:0] RESET_PC   = 32'd0,
    parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        halted,
    output logic        fetch_error
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_count,
    output logic [31:0] perf_redirect_count,
    output logic [31:0] perf_stall_count
`endif
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        ERR  = 2'd2
    } fetchState_t;

    localparam logic [31:0] DEPTH_W = 32'(IMEM_DEPTH);

    fetchState_t state_q;
    logic [31:0] pc_q;
    logic        ifValid_q;
    logic [31:0] ifInstr_q;
    logic [31:0] ifPc_q;
    logic        halted_q;
    logic        fetchError_q;

    logic        fire_d;
    logic        inRange_d;
    logic        capture_d;
    logic [31:0] pcInc_d;

    // A fetch fires only in RUN, with no redirect, when the output register is empty or being drained.
    assign fire_d    = (state_q == RUN) && !redirect_valid && (!ifValid_q || id_ready);
    assign inRange_d = (pc_q < DEPTH_W);
    assign capture_d = fire_d && inRange_d;
    assign pcInc_d   = pc_q + 32'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RUN;
            pc_q         <= RESET_PC;
            ifValid_q    <= 1'b0;
            ifInstr_q    <= 32'd0;
            ifPc_q       <= 32'd0;
            halted_q     <= 1'b0;
            fetchError_q <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (redirect_valid) begin
                        pc_q      <= redirect_target;
                        ifValid_q <= 1'b0;
                    end else if (fire_d) begin
                        if (inRange_d) begin
                            ifInstr_q <= imem_instr;
                            ifPc_q    <= pc_q;
                            ifValid_q <= 1'b1;
                            // The halt word is delivered but the PC parks on it.
                            if (imem_instr == HALT_WORD) begin
                                state_q  <= HALT;
                                halted_q <= 1'b1;
                            end else begin
                                pc_q <= pcInc_d;
                            end
                        end else begin
                            ifValid_q    <= 1'b0;
                            fetchError_q <= 1'b1;
                            state_q      <= ERR;
                        end
                    end
                end
                HALT, ERR: begin
                    if (ifValid_q && id_ready) begin
                        ifValid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ERR;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perfFetch_q;
    logic [31:0] perfRedirect_q;
    logic [31:0] perfStall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perfFetch_q    <= 32'd0;
            perfRedirect_q <= 32'd0;
            perfStall_q    <= 32'd0;
        end else begin
            if (capture_d) begin
                perfFetch_q <= perfFetch_q + 32'd1;
            end
            if (redirect_valid && (state_q == RUN)) begin
                perfRedirect_q <= perfRedirect_q + 32'd1;
            end
            if (ifValid_q && !id_ready) begin
                perfStall_q <= perfStall_q + 32'd1;
            end
        end
    end

    assign perf_fetch_count    = perfFetch_q;
    assign perf_redirect_count = perfRedirect_q;
    assign perf_stall_count    = perfStall_q;
`endif

    assign imem_pc     = pc_q;
    assign if_valid    = ifValid_q;
    assign if_instr    = ifInstr_q;
    assign if_pc       = ifPc_q;
    assign halted      = halted_q;
    assign fetch_error = fetchError_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: sequential fetch, stall, redirect, halt and out-of-range trapping.
module tb_pc_fetch_unit;

    logic        clk;
    logic        reset;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        halted;
    logic        fetch_error;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_count;
    logic [31:0] perf_redirect_count;
    logic [31:0] perf_stall_count;
`endif

    int errorCount;
    int checkCount;

    logic [31:0] memArr [32];

    pc_fetch_unit #(
        .IMEM_DEPTH(32),
        .RESET_PC  (32'd0),
        .HALT_WORD (32'hFFFF_FFFF)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .id_ready       (id_ready),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .halted         (halted),
        .fetch_error    (fetch_error)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_count   (perf_fetch_count),
        .perf_redirect_count(perf_redirect_count),
        .perf_stall_count   (perf_stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory word k holds k+0x100, except index 5 which holds the halt word.
    assign imem_instr = (imem_pc < 32'd32) ? memArr[imem_pc[4:0]] : 32'hDEAD_BEEF;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic redir, input logic [31:0] target, input logic ready);
        reset           = rst;
        redirect_valid  = redir;
        redirect_target = target;
        id_ready        = ready;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        errorCount = 0;
        checkCount = 0;
        for (int k = 0; k < 32; k++) memArr[k] = 32'h100 + 32'(k);
        memArr[5] = 32'hFFFF_FFFF;

        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
        stepCycle();
        checkOutput("rst_valid", {31'd0, if_valid}, 32'd0);
        checkOutput("rst_instr", if_instr, 32'd0);
        checkOutput("rst_ifpc", if_pc, 32'd0);
        checkOutput("rst_halted", {31'd0, halted}, 32'd0);
        checkOutput("rst_err", {31'd0, fetch_error}, 32'd0);
        checkOutput("rst_imempc", imem_pc, 32'd0);

        // Back-to-back fetch of indices 0..2.
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            checkOutput("seq_valid", {31'd0, if_valid}, 32'd1);
            checkOutput("seq_ifpc", if_pc, 32'(i));
            checkOutput("seq_instr", if_instr, 32'h100 + 32'(i));
            checkOutput("seq_imempc", imem_pc, 32'(i + 1));
        end

        // Decode stalls for three edges while index 2 is presented.
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            checkOutput("stall_valid", {31'd0, if_valid}, 32'd1);
            checkOutput("stall_ifpc", if_pc, 32'd2);
            checkOutput("stall_instr", if_instr, 32'h102);
            checkOutput("stall_imempc", imem_pc, 32'd3);
        end
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        stepCycle();
        checkOutput("resume_ifpc", if_pc, 32'd3);
        checkOutput("resume_instr", if_instr, 32'h103);
        checkOutput("resume_imempc", imem_pc, 32'd4);
`ifdef FETCH_PERF_EN
        checkOutput("perf_fetch_a", perf_fetch_count, 32'd4);
        checkOutput("perf_redir_a", perf_redirect_count, 32'd0);
        checkOutput("perf_stall_a", perf_stall_count, 32'd3);
`endif

        // Redirect to 10 while decode is stalled: flush wins.
        applyStimulus(1'b0, 1'b1, 32'd10, 1'b0);
        stepCycle();
        checkOutput("redir_flush", {31'd0, if_valid}, 32'd0);
        checkOutput("redir_imempc", imem_pc, 32'd10);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        stepCycle();
        checkOutput("redir_valid", {31'd0, if_valid}, 32'd1);
        checkOutput("redir_ifpc", if_pc, 32'd10);
        checkOutput("redir_instr", if_instr, 32'h10A);
`ifdef FETCH_PERF_EN
        checkOutput("perf_fetch_b", perf_fetch_count, 32'd5);
        checkOutput("perf_redir_b", perf_redirect_count, 32'd1);
        checkOutput("perf_stall_b", perf_stall_count, 32'd4);
`endif

        // Redirect to 4 and run into the halt word at 5.
        applyStimulus(1'b0, 1'b1, 32'd4, 1'b1);
        stepCycle();
        checkOutput("h_flush", {31'd0, if_valid}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        stepCycle();
        checkOutput("h_ifpc4", if_pc, 32'd4);
        checkOutput("h_halted0", {31'd0, halted}, 32'd0);
        stepCycle();
        checkOutput("h_instr", if_instr, 32'hFFFF_FFFF);
        checkOutput("h_valid", {31'd0, if_valid}, 32'd1);
        checkOutput("h_halted", {31'd0, halted}, 32'd1);
        checkOutput("h_imempc", imem_pc, 32'd5);
        stepCycle();
        checkOutput("h_drain", {31'd0, if_valid}, 32'd0);
        checkOutput("h_imempc2", imem_pc, 32'd5);
        applyStimulus(1'b0, 1'b1, 32'd0, 1'b1);
        stepCycle();
        checkOutput("h_redir_ign", imem_pc, 32'd5);
        checkOutput("h_still", {31'd0, halted}, 32'd1);

        // Reset out of HALT, then run off the end of memory.
        applyStimulus(1'b1, 1'b1, 32'd7, 1'b1);
        stepCycle();
        checkOutput("r2_halted", {31'd0, halted}, 32'd0);
        checkOutput("r2_imempc", imem_pc, 32'd0);
        applyStimulus(1'b0, 1'b1, 32'd31, 1'b1);
        stepCycle();
        checkOutput("e_imempc", imem_pc, 32'd31);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        stepCycle();
        checkOutput("e_ifpc31", if_pc, 32'd31);
        checkOutput("e_instr31", if_instr, 32'h11F);
        checkOutput("e_noerr", {31'd0, fetch_error}, 32'd0);
        checkOutput("e_imempc32", imem_pc, 32'd32);
        stepCycle();
        checkOutput("e_err", {31'd0, fetch_error}, 32'd1);
        checkOutput("e_valid0", {31'd0, if_valid}, 32'd0);
        applyStimulus(1'b0, 1'b1, 32'd0, 1'b1);
        stepCycle();
        checkOutput("e_nocap", if_pc, 32'd31);
        checkOutput("e_redir_ign", imem_pc, 32'd32);
        checkOutput("e_sticky", {31'd0, fetch_error}, 32'd1);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
        stepCycle();
        checkOutput("r3_err", {31'd0, fetch_error}, 32'd0);
        checkOutput("r3_imempc", imem_pc, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        stepCycle();
        checkOutput("r3_refetch", if_instr, 32'h100);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
